// File: rtl/hilo_ctrl.sv
// hilo_ctrl: operand latch, settle timer and HI/LO write-back for MULT/MULTU,
// plus MTHI/MTLO writes. The external multiplier is unsigned and combinational
// from mul_a/mul_b. Signed multiplies feed it magnitudes and then correct the
// sign on commit.
// Build option: define HILO_FWD_EN to forward MTHI/MTLO write data onto hi/lo
// combinationally in the request cycle.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | accepting requests; MTHI/MTLO write on the sampling edge
// WAIT  | multiply in flight; cnt counts down to the commit edge

module hilo_ctrl #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] prod_hi,
    input  logic [31:0] prod_lo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    localparam logic [3:0] LAT = 4'(MUL_LAT);

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;
    localparam logic [1:0] OP_MTLO  = 2'b11;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        neg, neg_n;
    logic [31:0] mul_a_q, mul_a_n;
    logic [31:0] mul_b_q, mul_b_n;
    logic [31:0] hi_q, hi_n;
    logic [31:0] lo_q, lo_n;
    logic        done_q, done_n;

    logic [31:0] a_mag, b_mag;
    logic [63:0] prod;
    logic [63:0] prod_fix;

    // Operand magnitudes and the sign-corrected product (full 64-bit negate).
    always_comb begin
        a_mag    = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
        b_mag    = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
        prod     = {prod_hi, prod_lo};
        prod_fix = neg ? (~prod + 64'd1) : prod;
    end

    // Next-state and next-register values for the sequencer.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        neg_n   = neg;
        mul_a_n = mul_a_q;
        mul_b_n = mul_b_q;
        hi_n    = hi_q;
        lo_n    = lo_q;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULTU: begin
                            mul_a_n = rs_val;
                            mul_b_n = rt_val;
                            neg_n   = 1'b0;
                            cnt_n   = LAT;
                            state_n = WAIT;
                        end
                        OP_MULT: begin
                            mul_a_n = a_mag;
                            mul_b_n = b_mag;
                            neg_n   = rs_val[31] ^ rt_val[31];
                            cnt_n   = LAT;
                            state_n = WAIT;
                        end
                        OP_MTHI: hi_n = rs_val;
                        OP_MTLO: lo_n = rs_val;
                        default: ;
                    endcase
                end
            end
            WAIT: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    {hi_n, lo_n} = prod_fix;
                    done_n       = 1'b1;
                    state_n      = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight multiply.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            neg     <= 1'b0;
            mul_a_q <= 32'd0;
            mul_b_q <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            neg     <= neg_n;
            mul_a_q <= mul_a_n;
            mul_b_q <= mul_b_n;
            hi_q    <= hi_n;
            lo_q    <= lo_n;
            done_q  <= done_n;
        end
    end

    assign mul_a = mul_a_q;
    assign mul_b = mul_b_q;
    assign busy  = (state == WAIT);
    assign done  = done_q;

`ifdef HILO_FWD_EN
    assign hi = (state == IDLE && start && op == OP_MTHI) ? rs_val : hi_q;
    assign lo = (state == IDLE && start && op == OP_MTLO) ? rs_val : lo_q;
`else
    assign hi = hi_q;
    assign lo = lo_q;
`endif

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl: a vector table of multiplies and HI/LO moves,
// followed by hand-written sequences for busy-ignore, back-to-back issue and
// reset during WAIT. A behavioural multiplier closes the mul_a/mul_b loop.

module tb_hilo_ctrl;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val, rt_val;
    logic [31:0] mul_a, mul_b;
    logic [31:0] prod_hi, prod_lo;
    logic [31:0] hi, lo;
    logic        busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    hilo_ctrl #(.MUL_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val),
        .mul_a(mul_a), .mul_b(mul_b),
        .prod_hi(prod_hi), .prod_lo(prod_lo),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    assign {prod_hi, prod_lo} = 64'(mul_a) * 64'(mul_b);

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs, rt;
        logic [31:0] e_hi, e_lo, e_mula, e_mulb;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000001};
        vecs[2] = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 32'h80000000, 32'h80000000};
        vecs[3] = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 32'h00000003, 32'h00000007};
        vecs[4] = '{2'b00, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 32'h00010000, 32'h00010000};
        vecs[5] = '{2'b01, 32'h00000005, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF6, 32'h00000005, 32'h00000002};
        vecs[6] = '{2'b01, 32'h00000000, 32'hFFFFFFFB, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000005};
        vecs[7] = '{2'b10, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000005};
        vecs[8] = '{2'b11, 32'h9ABCDEF0, 32'hDEADBEEF, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 32'h00000005};

        reset = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
        #3;
        check("rst hi", 64'(hi), 64'd0);
        check("rst lo", 64'(lo), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst mul_a", 64'(mul_a), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            start = 1'b1; op = vecs[i].op; rs_val = vecs[i].rs; rt_val = vecs[i].rt;
            if (vecs[i].op[1]) begin
                #1;
`ifdef HILO_FWD_EN
                if (vecs[i].op[0]) check($sformatf("v%0d fwd lo", i), 64'(lo), 64'(vecs[i].rs));
                else               check($sformatf("v%0d fwd hi", i), 64'(hi), 64'(vecs[i].rs));
`else
                if (vecs[i].op[0]) check($sformatf("v%0d pre lo", i), 64'(lo), 64'(vecs[i-1].e_lo));
                else               check($sformatf("v%0d pre hi", i), 64'(hi), 64'(vecs[i-1].e_hi));
`endif
                @(negedge clk);
                start = 1'b0;
                check($sformatf("v%0d hi", i), 64'(hi), 64'(vecs[i].e_hi));
                check($sformatf("v%0d lo", i), 64'(lo), 64'(vecs[i].e_lo));
                check($sformatf("v%0d busy", i), 64'(busy), 64'd0);
                check($sformatf("v%0d done", i), 64'(done), 64'd0);
                check($sformatf("v%0d mul_a hold", i), 64'(mul_a), 64'(vecs[i].e_mula));
                check($sformatf("v%0d mul_b hold", i), 64'(mul_b), 64'(vecs[i].e_mulb));
            end else begin
                @(negedge clk);
                start = 1'b0;
                check($sformatf("v%0d busy0", i), 64'(busy), 64'd1);
                check($sformatf("v%0d mul_a", i), 64'(mul_a), 64'(vecs[i].e_mula));
                check($sformatf("v%0d mul_b", i), 64'(mul_b), 64'(vecs[i].e_mulb));
                for (int k = 1; k <= LAT; k++) begin
                    @(negedge clk);
                    if (k < LAT) begin
                        check($sformatf("v%0d busy%0d", i, k), 64'(busy), 64'd1);
                        check($sformatf("v%0d done%0d", i, k), 64'(done), 64'd0);
                    end else begin
                        check($sformatf("v%0d busy end", i), 64'(busy), 64'd0);
                        check($sformatf("v%0d done pulse", i), 64'(done), 64'd1);
                        check($sformatf("v%0d hi", i), 64'(hi), 64'(vecs[i].e_hi));
                        check($sformatf("v%0d lo", i), 64'(lo), 64'(vecs[i].e_lo));
                    end
                end
                @(negedge clk);
                check($sformatf("v%0d done low", i), 64'(done), 64'd0);
            end
        end

        // start while busy is ignored: MULTU 2x2 then a held MULTU 3x5
        @(negedge clk);
        start = 1'b1; op = 2'b00; rs_val = 32'd2; rt_val = 32'd2;
        @(negedge clk);
        rs_val = 32'd3; rt_val = 32'd5;
        check("ign busy", 64'(busy), 64'd1);
        @(negedge clk);
        start = 1'b0;
        check("ign mul_a", 64'(mul_a), 64'd2);
        check("ign mul_b", 64'(mul_b), 64'd2);
        @(negedge clk);
        check("ign done", 64'(done), 64'd1);
        check("ign hilo", {hi, lo}, 64'd4);
        @(negedge clk);
        check("ign idle", 64'(busy), 64'd0);
        check("ign no redo", 64'(done), 64'd0);
        check("ign mul_a after", 64'(mul_a), 64'd2);
        check("ign hilo after", {hi, lo}, 64'd4);

        // back-to-back: second start accepted in the done cycle
        @(negedge clk);
        start = 1'b1; op = 2'b00; rs_val = 32'd3; rt_val = 32'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("b2b done1", 64'(done), 64'd1);
        check("b2b hilo1", {hi, lo}, 64'd15);
        start = 1'b1; op = 2'b00; rs_val = 32'd7; rt_val = 32'd6;
        @(negedge clk);
        start = 1'b0;
        check("b2b busy2", 64'(busy), 64'd1);
        check("b2b done low", 64'(done), 64'd0);
        check("b2b mul_a2", 64'(mul_a), 64'd7);
        @(negedge clk);
        @(negedge clk);
        check("b2b done2", 64'(done), 64'd1);
        check("b2b hilo2", {hi, lo}, 64'd42);

        // reset mid-WAIT after a commit left HI=0xFFFFFFFF
        @(negedge clk);
        start = 1'b1; op = 2'b01; rs_val = 32'hFFFFFFFF; rt_val = 32'd1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rw pre hi", 64'(hi), 64'hFFFFFFFF);
        @(negedge clk);
        start = 1'b1; op = 2'b00; rs_val = 32'd3; rt_val = 32'd3;
        @(negedge clk);
        start = 1'b0;
        check("rw busy", 64'(busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("rw hi", 64'(hi), 64'd0);
        check("rw lo", 64'(lo), 64'd0);
        check("rw busy0", 64'(busy), 64'd0);
        check("rw done0", 64'(done), 64'd0);
        check("rw mul_a", 64'(mul_a), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("rw post busy%0d", k), 64'(busy), 64'd0);
            check($sformatf("rw post done%0d", k), 64'(done), 64'd0);
            check($sformatf("rw post hilo%0d", k), {hi, lo}, 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
